// File: rtl/max_unpool_backward.sv
// Gradient router for 2x2/stride-2 max pooling: records per-channel argmax over one forward
// row pair, then scatters the pooled gradients back to the argmax positions, zeros elsewhere.
module max_unpool_backward #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned D         = 32,
  parameter int unsigned W         = 92
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fwd_valid,
  output logic                   fwd_ready,
  input  logic [D*DATA_BITS-1:0] fwd_data,
  input  logic                   grad_valid,
  output logic                   grad_ready,
  input  logic [D*DATA_BITS-1:0] grad_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D*DATA_BITS-1:0] out_data,
  output logic                   pair_done
);

  localparam int unsigned PW = D * DATA_BITS;
  localparam int unsigned KW = (W > 2) ? $clog2(W / 2) : 1;
  localparam int unsigned CW = KW + 1;
  localparam logic [CW-1:0] LastCol = CW'(W - 1);

  typedef enum logic [1:0] {StFwdTop, StFwdBot, StBwdTop, StBwdBot} state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   out_col_q;
  logic [CW-1:0]   out_col_nxt;
  logic [KW-1:0]   win_q;
  logic [KW-1:0]   col_win;
  logic [KW-1:0]   out_win;
  logic [KW-1:0]   nxt_win;
  logic            out_valid_q;
  logic [PW-1:0]   out_data_q;
  logic [PW-1:0]   bot_even_q;
  logic [PW-1:0]   top_buf  [W];
  logic [PW-1:0]   grad_buf [W/2];
  logic [2*D-1:0]  idx_buf  [W/2];
  logic            fwd_hs;
  logic            grad_hs;
  logic            out_hs;

  // Per-channel 2-bit argmax; strict greater-than keeps the earliest candidate on ties.
  function automatic logic [2*D-1:0] argmax(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [PW-1:0] c, input logic [PW-1:0] dv);
    logic [2*D-1:0]              r;
    logic signed [DATA_BITS-1:0] best;
    logic signed [DATA_BITS-1:0] vb;
    logic signed [DATA_BITS-1:0] vc;
    logic signed [DATA_BITS-1:0] vd;
    r = '0;
    for (int unsigned ch = 0; ch < D; ch++) begin
      best = $signed(a[ch*DATA_BITS +: DATA_BITS]);
      vb   = $signed(b[ch*DATA_BITS +: DATA_BITS]);
      vc   = $signed(c[ch*DATA_BITS +: DATA_BITS]);
      vd   = $signed(dv[ch*DATA_BITS +: DATA_BITS]);
      r[2*ch +: 2] = 2'd0;
      if (vb > best) begin
        best = vb;
        r[2*ch +: 2] = 2'd1;
      end
      if (vc > best) begin
        best = vc;
        r[2*ch +: 2] = 2'd2;
      end
      if (vd > best) begin
        r[2*ch +: 2] = 2'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] unpool(input logic [PW-1:0] g, input logic [2*D-1:0] idx,
                                           input logic [1:0] pos);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned ch = 0; ch < D; ch++) begin
      if (idx[2*ch +: 2] == pos) r[ch*DATA_BITS +: DATA_BITS] = g[ch*DATA_BITS +: DATA_BITS];
    end
    return r;
  endfunction

  assign fwd_ready   = (state_q == StFwdTop) || (state_q == StFwdBot);
  // A new gradient may enter only once the odd (second) beat of its predecessor is leaving.
  assign grad_ready  = (state_q == StBwdTop) &&
                       (!out_valid_q || (out_ready && out_col_q[0] && (out_col_q != LastCol)));
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign fwd_hs      = fwd_valid && fwd_ready;
  assign grad_hs     = grad_valid && grad_ready;
  assign out_hs      = out_valid_q && out_ready;
  assign pair_done   = out_hs && (state_q == StBwdBot) && (out_col_q == LastCol);

  assign col_win     = col_q[CW-1:1];
  assign out_win     = out_col_q[CW-1:1];
  assign out_col_nxt = out_col_q + CW'(1);
  assign nxt_win     = out_col_nxt[CW-1:1];

  // Buffers carry no reset; their contents are only read after being written in a row pair.
  always_ff @(posedge clk) begin
    if (fwd_hs && (state_q == StFwdTop)) top_buf[col_q] <= fwd_data;
    if (fwd_hs && (state_q == StFwdBot)) begin
      if (!col_q[0]) begin
        bot_even_q <= fwd_data;
      end else begin
        idx_buf[col_win] <= argmax(top_buf[{col_win, 1'b0}], top_buf[col_q], bot_even_q,
                                   fwd_data);
      end
    end
    if (grad_hs) grad_buf[win_q] <= grad_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFwdTop;
      col_q       <= '0;
      out_col_q   <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StFwdTop, StFwdBot: begin
          if (fwd_hs) begin
            if (col_q == LastCol) begin
              col_q     <= '0;
              out_col_q <= '0;
              win_q     <= '0;
              state_q   <= (state_q == StFwdTop) ? StFwdBot : StBwdTop;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        StBwdTop: begin
          if (grad_hs) begin
            out_valid_q <= 1'b1;
            out_col_q   <= {win_q, 1'b0};
            out_data_q  <= unpool(grad_data, idx_buf[win_q], 2'd0);
            win_q       <= win_q + KW'(1);
          end else if (out_hs) begin
            if (!out_col_q[0]) begin
              out_col_q  <= out_col_nxt;
              out_data_q <= unpool(grad_buf[out_win], idx_buf[out_win], 2'd1);
            end else if (out_col_q == LastCol) begin
              state_q    <= StBwdBot;
              out_col_q  <= '0;
              out_data_q <= unpool(grad_buf[KW'(0)], idx_buf[KW'(0)], 2'd2);
            end else begin
              out_valid_q <= 1'b0;
            end
          end
        end
        StBwdBot: begin
          if (out_hs) begin
            if (out_col_q == LastCol) begin
              out_valid_q <= 1'b0;
              col_q       <= '0;
              state_q     <= StFwdTop;
            end else begin
              out_col_q  <= out_col_nxt;
              out_data_q <= unpool(grad_buf[nxt_win], idx_buf[nxt_win], {1'b1, out_col_nxt[0]});
            end
          end
        end
      endcase
    end
  end

endmodule
